// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: one request, one captured
// instruction held for the consumer, then the next PC (sequential or target).
module instr_fetch #(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         PCSel,
  input  logic [n-1:0] alu_out,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [n-1:0] imem_rdata,
  output logic [n-1:0] instr,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic [31:0]  retired,
  output logic         misalign_err
);

  localparam logic [n-1:0] NOP  = n'(32'h0000_0013);
  localparam logic [n-1:0] FOUR = n'(4);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [n-1:0] r_pc;
  logic [n-1:0] r_instr;
  logic         r_instr_valid;
  logic [31:0]  r_retired;
  logic         r_misalign;

  logic [n-1:0] w_pc_plus4;
  logic [n-1:0] w_next_pc;
  logic         w_misaligned;
  logic         w_capture;
  logic         w_complete;

  // Redirect inputs only matter on the completing edge, so they are folded
  // into w_next_pc and consumed solely under w_complete.
  assign w_pc_plus4   = r_pc + FOUR;
  assign w_next_pc    = PCSel ? alu_out : w_pc_plus4;
  assign w_misaligned = |w_next_pc[1:0];
  assign w_capture    = (r_state == WAIT) && imem_rvalid;
  assign w_complete   = (r_state == HOLD) && instr_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = REQ;
      REQ:     if (imem_gnt) w_state_nxt = WAIT;
      WAIT:    if (imem_rvalid) w_state_nxt = HOLD;
      HOLD:    if (instr_ready) w_state_nxt = w_misaligned ? HALT : REQ;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_instr_valid <= 1'b0;
      r_retired     <= 32'd0;
      r_misalign    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      // A misaligned target retires the current instruction but leaves pc
      // pointing at it, so the halted state shows where the fault came from.
      if (w_complete) begin
        r_instr_valid <= 1'b0;
        r_retired     <= r_retired + 32'd1;
        if (w_misaligned) r_misalign <= 1'b1;
        else              r_pc       <= w_next_pc;
      end
    end
  end

  assign imem_req     = (r_state == REQ);
  assign imem_addr    = r_pc;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign retired      = r_retired;
  assign misalign_err = r_misalign;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter n, default 32: the data and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: the fetch address after reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port PCSel, input, 1 bit: comes from control; 1 means the next PC is alu_out, 0 means pc+4.
REQ-006 Port alu_out, input, n bits: the branch or jump target.
REQ-007 Port imem_req, output, 1 bit: instruction-memory request.
REQ-008 Port imem_addr, output, n bits: the request address, which always equals pc.
REQ-009 Port imem_gnt, input, 1 bit: the memory accepts the request this cycle.
REQ-010 Port imem_rvalid, input, 1 bit: the read data is valid this cycle.
REQ-011 Port imem_rdata, input, n bits: the read data.
REQ-012 Port instr, output, n bits: the registered instruction delivered to decode/control.
REQ-013 Port instr_valid, output, 1 bit: instr holds a fetched instruction.
REQ-014 Port instr_ready, input, 1 bit: the consumer completes the instruction this cycle.
REQ-015 Port pc, output, n bits: the address of the current instruction.
REQ-016 Port pc_plus4, output, n bits: pc+4, combinational, modulo 2^n.
REQ-017 Port retired, output, 32 bits: the count of completed instructions.
REQ-018 Port misalign_err, output, 1 bit: sticky flag for a misaligned target.

Function
REQ-019 The state machine SHALL have the states IDLE, REQ, WAIT, HOLD and HALT, with IDLE as the reset state.
REQ-020 IDLE SHALL go unconditionally to REQ on the next edge, with imem_req=0.
REQ-021 In REQ, imem_req SHALL be 1 and imem_addr SHALL be pc; imem_gnt=1 goes to WAIT, otherwise the block stays in REQ with the address held stable.
REQ-022 In WAIT, imem_req SHALL be 0; imem_rvalid=1 captures imem_rdata into instr, sets instr_valid=1 on the same edge, and goes to HOLD.
REQ-023 imem_rvalid SHALL be ignored in IDLE, REQ, HOLD and HALT (no capture, no state change).
REQ-024 Only one request SHALL be outstanding at any time; there is no prefetch.
REQ-025 In HOLD, instr_valid=1 and instr stays stable until instr_ready=1.
REQ-026 On instr_ready=1 in HOLD, the next PC SHALL be computed as PCSel ? alu_out : pc+4.
REQ-027 If that next PC has bits [1:0]==2'b00: pc takes it, instr_valid clears, retired increments, and the state goes to REQ, all on the same edge.
REQ-028 If that next PC has bits [1:0]!=2'b00: pc is unchanged, instr_valid clears, retired increments, misalign_err is set, and the state goes to HALT.
REQ-029 PCSel and alu_out SHALL be sampled only on the completing edge of REQ-026; their values at all other times have no effect.
REQ-030 The minimum throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD), given imem_gnt and imem_rvalid each asserted at first opportunity and instr_ready=1.
REQ-031 pc+4 SHALL wrap modulo 2^n: pc=32'hFFFF_FFFC yields 32'h0000_0000, with no error.
REQ-032 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-033 HALT SHALL be absorbing until reset, with imem_req=0, instr_valid=0 and misalign_err=1.
REQ-034 instr_ready=1 while instr_valid=0 SHALL have no effect.

Reset
REQ-035 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, retired=0, misalign_err=0.
REQ-036 Reset asserted mid-WAIT SHALL abandon the outstanding request, and a late imem_rvalid after reset SHALL be discarded per REQ-023.
REQ-037 After rst_n rises, the first imem_req SHALL appear 1 cycle later (IDLE to REQ), with imem_addr=RESET_PC.

Verification
REQ-038 Sequential fetch: reset release, with imem_gnt, imem_rvalid and instr_ready tied to 1 and rdata=32'h0000_0013 -> imem_addr sequence 0,4,8, one instruction per 3 cycles, retired=3 after the third completion.
REQ-039 Taken branch: PCSel=1 and alu_out=32'h0000_0100 at completion from pc=8 -> next imem_addr=32'h100 and pc_plus4=32'h104.
REQ-040 Back-pressure: instr_ready=0 for 5 cycles in HOLD -> instr and pc stable, no imem_req, retired unchanged; completion on the 6th cycle.
REQ-041 Memory stall: imem_gnt=0 for 4 cycles -> imem_req=1 with imem_addr held; then imem_rvalid delayed 3 cycles -> instr_valid rises only on the rvalid edge.
REQ-042 Misaligned target: PCSel=1 and alu_out=32'h0000_0102 -> misalign_err=1, state HALT, no further imem_req; rst_n=0 clears the error.
REQ-043 Reset in WAIT: rst_n pulsed low, then imem_rvalid=1 arriving in IDLE -> instr=32'h0000_0013, instr_valid=0, and the next request is at RESET_PC.
